// File: rtl/game_event_tx.sv
// Queues game events and replays each on the processor input lines for HOLD_CYCLES clocks, followed by a GAP_CYCLES idle gap.
// Latency: an event accepted into an empty, idle block reaches the lines one clock later; each event then occupies HOLD+GAP+1 clocks.
// Backpressure: ev_ready drops while the FIFO is full, and every refused ev_valid cycle increments a saturating drop counter.
module game_event_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [1:0] ev_kind,
  input  logic [3:0] ev_payload,
  output logic [2:0] addPoints,
  output logic [3:0] blockType,
  output logic       rotate,
  output logic [1:0] fromGame,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   FCNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [1:0] K_SCORE  = 2'd0;
  localparam logic [1:0] K_SPAWN  = 2'd1;
  localparam logic [1:0] K_ROTATE = 2'd2;
  localparam logic [1:0] K_STATUS = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_GAP = 2'd2} state_t;

  // FIFO storage: entry is {kind, payload}
  logic [5:0]    mem_q [FIFO_DEPTH];
  logic [5:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   fcnt_q, fcnt_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    points_q, points_d;
  logic [3:0]    block_q, block_d;
  logic          rot_q, rot_d;
  logic [1:0]    status_q, status_d;
  logic [7:0]    drops_q, drops_d;

  logic       push, pop, fifo_empty, zero_score;
  logic [5:0] head;
  logic [1:0] head_kind;
  logic [3:0] head_pay;

  // Ready depends on occupancy only, so a pop in the same cycle never frees room for a refused event
  assign fifo_empty = (fcnt_q == '0);
  assign ev_ready   = (fcnt_q != FIFO_FULL);
  assign push       = ev_valid && ev_ready;
  assign head       = mem_q[rd_q];
  assign head_kind  = head[5:4];
  assign head_pay   = head[3:0];
  assign zero_score = (head_kind == K_SCORE) && (head_pay[2:0] == 3'd0);

  assign addPoints  = points_q;
  assign blockType  = block_q;
  assign rotate     = rot_q;
  assign fromGame   = status_q;
  assign drop_count = drops_q;
  assign busy       = !fifo_empty || (state_q != S_IDLE);

  // FIFO next state: simultaneous push and pop both take effect
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    if (push) begin
      mem_d[wr_q] = {ev_kind, ev_payload};
      wr_d        = wr_q + PTR_ONE;
    end
    if (pop) begin
      rd_d = rd_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + FCNT_ONE;
      2'b01:   fcnt_d = fcnt_q - FCNT_ONE;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Refused-event counter, sticky at 255
  always_comb begin
    drops_d = drops_q;
    if (ev_valid && !ev_ready && (drops_q != 8'hFF)) begin
      drops_d = drops_q + 8'd1;
    end
  end

  // FSM next state: zero-point scores are dropped without taking a hold slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty && !zero_score) state_d = S_HOLD;
      S_HOLD: if (cnt_q == CNT_ZERO) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (cnt_q == CNT_ZERO) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pop and apply the head in IDLE, time the hold and gap, clear pulse lines at hold end
  always_comb begin
    pop      = 1'b0;
    cnt_d    = cnt_q;
    points_d = points_q;
    block_d  = block_q;
    rot_d    = rot_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head_kind)
            K_SCORE:  if (!zero_score) points_d = head_pay[2:0];
            K_SPAWN:  block_d  = head_pay;
            K_ROTATE: rot_d    = 1'b1;
            K_STATUS: status_d = head_pay[1:0];
            default:  ;
          endcase
          if (!zero_score) cnt_d = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          points_d = 3'd0;
          rot_d    = 1'b0;
          cnt_d    = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
      end
      default: ;
    endcase
  end

  // State register: reset abandons any event in flight and empties the queue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      points_q <= '0;
      block_q  <= '0;
      rot_q    <= 1'b0;
      status_q <= '0;
      drops_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      fcnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      points_q <= points_d;
      block_q  <= block_d;
      rot_q    <= rot_d;
      status_q <= status_d;
      drops_q  <= drops_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      fcnt_q   <= fcnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_game_event_tx.sv
// Directed bench for game_event_tx with default parameters (depth 4, hold 8, gap 4).
// Single events come from a vector table; burst, overflow, zero-score and reset cases are hand sequences.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_game_event_tx;

  logic       clock;
  logic       reset;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_kind;
  logic [3:0] ev_payload;
  logic [2:0] addPoints;
  logic [3:0] blockType;
  logic       rotate;
  logic [1:0] fromGame;
  logic       busy;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  game_event_tx dut (
    .clock      (clock),
    .reset      (reset),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_kind    (ev_kind),
    .ev_payload (ev_payload),
    .addPoints  (addPoints),
    .blockType  (blockType),
    .rotate     (rotate),
    .fromGame   (fromGame),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] kind;
    logic [3:0] pay;
    logic [2:0] pts;
    logic [3:0] blk;
    logic       rot;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_tick(input logic [1:0] k, input logic [3:0] p);
    ev_valid   = 1'b1;
    ev_kind    = k;
    ev_payload = p;
    tick();
    ev_valid   = 1'b0;
  endtask

  task automatic chk_lines(input string tag, input logic [2:0] pts, input logic [3:0] blk,
                           input logic rot, input logic [1:0] st);
    chk({tag, " addPoints"}, 32'(addPoints), 32'(pts));
    chk({tag, " blockType"}, 32'(blockType), 32'(blk));
    chk({tag, " rotate"},    32'(rotate),    32'(rot));
    chk({tag, " fromGame"},  32'(fromGame),  32'(st));
  endtask

  // Absolute bound on run time in case the sequence below stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] bk [4];
    logic [3:0] bp [4];
    logic [2:0] e_pts;
    logic [3:0] e_blk;
    logic       e_rot;
    logic [1:0] e_st;

    vecs[0] = '{kind: 2'd0, pay: 4'h5, pts: 3'd5, blk: 4'h0, rot: 1'b0, st: 2'd0};
    vecs[1] = '{kind: 2'd1, pay: 4'h3, pts: 3'd0, blk: 4'h3, rot: 1'b0, st: 2'd0};
    vecs[2] = '{kind: 2'd2, pay: 4'hF, pts: 3'd0, blk: 4'h3, rot: 1'b1, st: 2'd0};
    vecs[3] = '{kind: 2'd3, pay: 4'hD, pts: 3'd0, blk: 4'h3, rot: 1'b0, st: 2'd1};
    vecs[4] = '{kind: 2'd0, pay: 4'hF, pts: 3'd7, blk: 4'h3, rot: 1'b0, st: 2'd1};
    vecs[5] = '{kind: 2'd1, pay: 4'hC, pts: 3'd0, blk: 4'hC, rot: 1'b0, st: 2'd1};
    vecs[6] = '{kind: 2'd0, pay: 4'h9, pts: 3'd1, blk: 4'hC, rot: 1'b0, st: 2'd1};

    // ---- reset state ----
    reset      = 1'b0;
    ev_valid   = 1'b0;
    ev_kind    = 2'd0;
    ev_payload = 4'd0;
    #1;
    chk_lines("reset", 3'd0, 4'd0, 1'b0, 2'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ev_ready", 32'(ev_ready), 32'd1);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    tick();
    tick();
    #3;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_lines($sformatf("idle%0d", i), 3'd0, 4'd0, 1'b0, 2'd0);
      chk($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
    end

    // ---- table: one event at a time from idle ----
    for (int v = 0; v < 7; v++) begin
      push_tick(vecs[v].kind, vecs[v].pay);
      chk($sformatf("vec%0d busy@k", v), 32'(busy), 32'd1);
      chk($sformatf("vec%0d pts@k", v), 32'(addPoints), 32'd0);
      for (int n = 1; n <= 8; n++) begin
        tick();
        chk_lines($sformatf("vec%0d hold%0d", v, n), vecs[v].pts, vecs[v].blk, vecs[v].rot, vecs[v].st);
      end
      tick();
      chk_lines($sformatf("vec%0d gap", v), 3'd0, vecs[v].blk, 1'b0, vecs[v].st);
      tick();
      tick();
      tick();
      chk($sformatf("vec%0d busy@k+12", v), 32'(busy), 32'd1);
      tick();
      chk($sformatf("vec%0d busy@k+13", v), 32'(busy), 32'd0);
    end

    // ---- burst: score 3, rotate, spawn A, status 2 on consecutive edges ----
    bk[0] = 2'd0; bp[0] = 4'h3;
    bk[1] = 2'd2; bp[1] = 4'h0;
    bk[2] = 2'd1; bp[2] = 4'hA;
    bk[3] = 2'd3; bp[3] = 4'h2;
    push_tick(bk[0], bp[0]);
    for (int n = 1; n <= 54; n++) begin
      if (n <= 3) begin
        ev_valid   = 1'b1;
        ev_kind    = bk[n];
        ev_payload = bp[n];
      end else begin
        ev_valid = 1'b0;
      end
      tick();
      e_pts = (n >= 1 && n <= 8) ? 3'd3 : 3'd0;
      e_rot = (n >= 14 && n <= 21);
      e_blk = (n >= 27) ? 4'hA : 4'hC;
      e_st  = (n >= 40) ? 2'd2 : 2'd1;
      chk_lines($sformatf("burst n=%0d", n), e_pts, e_blk, e_rot, e_st);
      if (n == 51) chk("burst busy@51", 32'(busy), 32'd1);
      if (n == 52) chk("burst busy@52", 32'(busy), 32'd0);
    end
    ev_valid = 1'b0;

    // ---- overflow: seven scores 1..7 pushed back to back ----
    for (int n = 0; n <= 70; n++) begin
      if (n <= 6) begin
        chk($sformatf("ovf ready before k+%0d", n), 32'(ev_ready), (n <= 4) ? 32'd1 : 32'd0);
        ev_valid   = 1'b1;
        ev_kind    = 2'd0;
        ev_payload = 4'(n + 1);
      end else begin
        ev_valid = 1'b0;
      end
      tick();
      if (n >= 1 && ((n - 1) % 13) == 0 && n <= 53)
        chk($sformatf("ovf order n=%0d", n), 32'(addPoints), 32'((n - 1) / 13 + 1));
      if (n >= 1 && ((n - 1) % 13) == 8)
        chk($sformatf("ovf gap n=%0d", n), 32'(addPoints), 32'd0);
      if (n == 6) chk("ovf drop_count", 32'(drop_count), 32'd2);
      if (n == 64) chk("ovf busy@64", 32'(busy), 32'd1);
      if (n == 65) chk("ovf busy@65", 32'(busy), 32'd0);
      if (n == 70) chk("ovf tail addPoints", 32'(addPoints), 32'd0);
    end
    chk("ovf drop_count final", 32'(drop_count), 32'd2);

    // ---- zero score is discarded, next score follows one cycle later ----
    push_tick(2'd0, 4'h8);
    chk("zero busy@k", 32'(busy), 32'd1);
    push_tick(2'd0, 4'h7);
    chk("zero pts@k+1", 32'(addPoints), 32'd0);
    chk("zero busy@k+1", 32'(busy), 32'd1);
    for (int n = 2; n <= 10; n++) begin
      tick();
      chk($sformatf("zero pts n=%0d", n), 32'(addPoints), (n <= 9) ? 32'd7 : 32'd0);
    end
    tick(); tick(); tick();
    chk("zero busy@k+13", 32'(busy), 32'd1);
    tick();
    chk("zero busy@k+14", 32'(busy), 32'd0);

    // ---- reset during a rotate pulse with a spawn queued behind it ----
    push_tick(2'd2, 4'h0);
    push_tick(2'd1, 4'h5);
    chk("rst rotate on", 32'(rotate), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("rst rotate drop", 32'(rotate), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ev_ready", 32'(ev_ready), 32'd1);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    chk("rst blockType", 32'(blockType), 32'd0);
    chk("rst fromGame", 32'(fromGame), 32'd0);
    #2;
    reset = 1'b1;
    tick();
    chk("post-rst busy", 32'(busy), 32'd0);
    chk("post-rst blockType", 32'(blockType), 32'd0);
    push_tick(2'd0, 4'h6);
    tick();
    chk_lines("post-rst event", 3'd6, 4'd0, 1'b0, 2'd0);
    chk("post-rst drop_count", 32'(drop_count), 32'd0);
    for (int n = 2; n <= 13; n++) tick();
    chk("post-rst idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
